gshare_spec_bp: RTL

- Next-generation gshare conditional-branch direction predictor for the OoO core; lives in fetch, trained from ROB commit.
- Adds speculative global history updated at predict time, architectural history updated at commit, and spec-history repair on flush.
- Counter width and history length are parametrised.
- Carries the PHT index with the instruction so training hits the same entry that produced the prediction; counts committed branches and mispredicts.

---
 rtl/gshare_spec_bp_if.sv | 32 +++
 rtl/gshare_spec_bp.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gshare_spec_bp_if.sv
// Predict/commit/status bundle for the gshare speculative predictor.
// master drives fetch and commit inputs; slave is the predictor.
interface gshare_spec_bp_if #(
  parameter int GHR_LENGTH = 30,
  parameter int PHT_DEPTH  = 8,
  parameter int PERF_WIDTH = 32
);
  logic [31:0]           pred_pc;
  logic                  pred_update;
  logic                  pred_take;
  logic [PHT_DEPTH-1:0]  pred_index;
  logic                  commit_valid;
  logic                  commit_is_br;
  logic                  commit_taken;
  logic [PHT_DEPTH-1:0]  commit_index;
  logic                  flush;
  logic [GHR_LENGTH-1:0] spec_ghr;
  logic [PERF_WIDTH-1:0] perf_br_cnt;
  logic [PERF_WIDTH-1:0] perf_mispred_cnt;

  modport master (
    output pred_pc, pred_update, commit_valid, commit_is_br, commit_taken,
           commit_index, flush,
    input  pred_take, pred_index, spec_ghr, perf_br_cnt, perf_mispred_cnt
  );

  modport slave (
    input  pred_pc, pred_update, commit_valid, commit_is_br, commit_taken,
           commit_index, flush,
    output pred_take, pred_index, spec_ghr, perf_br_cnt, perf_mispred_cnt
  );
endinterface

// File: rtl/gshare_spec_bp.sv
// Gshare direction predictor with speculative global history, commit-time
// architectural history, flush repair and committed-branch perf counters.
module gshare_spec_bp #(
  parameter int GHR_LENGTH = 30,
  parameter int PHT_DEPTH  = 8,
  parameter int CTR_BITS   = 2,
  parameter int PERF_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  gshare_spec_bp_if.slave bp
);
  localparam int PHT_ENTRIES = 2 ** PHT_DEPTH;

  localparam logic [CTR_BITS-1:0]   CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_ZERO  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]   CTR_ONE   = CTR_BITS'(1);
  // All-ones shifted right by one is 2**(CTR_BITS-1)-1: weakly not-taken.
  localparam logic [CTR_BITS-1:0]   CTR_INIT  = CTR_MAX >> 1;
  localparam logic [PERF_WIDTH-1:0] PERF_MAX  = {PERF_WIDTH{1'b1}};
  localparam logic [PERF_WIDTH-1:0] PERF_ZERO = {PERF_WIDTH{1'b0}};
  localparam logic [PERF_WIDTH-1:0] PERF_ONE  = PERF_WIDTH'(1);
  localparam logic [GHR_LENGTH-1:0] GHR_ZERO  = {GHR_LENGTH{1'b0}};

  function automatic logic [CTR_BITS-1:0] ctr_step(
    input logic [CTR_BITS-1:0] ctr,
    input logic                up
  );
    logic [CTR_BITS-1:0] res;
    if (up) begin
      if (ctr == CTR_MAX) res = ctr;
      else                res = ctr + CTR_ONE;
    end else begin
      if (ctr == CTR_ZERO) res = ctr;
      else                 res = ctr - CTR_ONE;
    end
    return res;
  endfunction

  function automatic logic [PERF_WIDTH-1:0] perf_inc(
    input logic [PERF_WIDTH-1:0] cnt
  );
    logic [PERF_WIDTH-1:0] res;
    if (cnt == PERF_MAX) res = cnt;
    else                 res = cnt + PERF_ONE;
    return res;
  endfunction

  logic [GHR_LENGTH-1:0] spec_ghr_r;
  logic [GHR_LENGTH-1:0] arch_ghr_r;
  logic [CTR_BITS-1:0]   pht_r [PHT_ENTRIES];
  logic [PERF_WIDTH-1:0] br_cnt_r;
  logic [PERF_WIDTH-1:0] mispred_cnt_r;

  logic [PHT_DEPTH-1:0]  idx_s;
  logic                  take_s;
  logic                  train_s;
  logic [GHR_LENGTH-1:0] arch_next_s;
  logic [GHR_LENGTH-1:0] spec_next_s;
  logic                  unused_pc_s;

  // PC bits outside the index window play no part in prediction.
  assign unused_pc_s = ^{bp.pred_pc[31:PHT_DEPTH+2], bp.pred_pc[1:0]};

  // Prediction lookup, history next-state and flush-over-predict priority.
  always_comb begin
    idx_s       = spec_ghr_r[PHT_DEPTH-1:0] ^ bp.pred_pc[PHT_DEPTH+1:2];
    take_s      = pht_r[idx_s][CTR_BITS-1];
    train_s     = bp.commit_valid & bp.commit_is_br;
    arch_next_s = arch_ghr_r;
    spec_next_s = spec_ghr_r;
    if (train_s) begin
      arch_next_s = {arch_ghr_r[GHR_LENGTH-2:0], bp.commit_taken};
    end else begin
      arch_next_s = arch_ghr_r;
    end
    // Repair uses the history that includes this cycle's commit.
    if (bp.flush) begin
      spec_next_s = arch_next_s;
    end else if (bp.pred_update) begin
      spec_next_s = {spec_ghr_r[GHR_LENGTH-2:0], take_s};
    end else begin
      spec_next_s = spec_ghr_r;
    end
  end

  // Speculative/architectural history and saturating perf counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr_r    <= GHR_ZERO;
      arch_ghr_r    <= GHR_ZERO;
      br_cnt_r      <= PERF_ZERO;
      mispred_cnt_r <= PERF_ZERO;
    end else begin
      spec_ghr_r <= spec_next_s;
      arch_ghr_r <= arch_next_s;
      if (train_s) begin
        br_cnt_r <= perf_inc(br_cnt_r);
        if (bp.flush) begin
          mispred_cnt_r <= perf_inc(mispred_cnt_r);
        end
      end
    end
  end

  // Pattern history table training; a same-cycle lookup sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_r[i] <= CTR_INIT;
      end
    end else if (train_s) begin
      pht_r[bp.commit_index] <= ctr_step(pht_r[bp.commit_index], bp.commit_taken);
    end
  end

  assign bp.pred_take        = take_s;
  assign bp.pred_index       = idx_s;
  assign bp.spec_ghr         = spec_ghr_r;
  assign bp.perf_br_cnt      = br_cnt_r;
  assign bp.perf_mispred_cnt = mispred_cnt_r;
endmodule
